// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller for a 5-stage MIPS-style core.
// Resolves stage stall requests into a freeze vector and turns memory-stage
// exceptions into a one-cycle flush with a PC redirect. After each flush it
// spends one BLANK cycle, so a stale exception code cannot flush twice.
// It also keeps a saturating count of taken exceptions and a sticky stall
// watchdog.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout_o,
  output logic [15:0] exc_count_o
);

  typedef enum logic {
    RUN   = 1'b0,
    BLANK = 1'b1
  } state_t;

  localparam logic [31:0] EXC_ERET   = 32'h0000_000e;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_0020;
  localparam logic [8:0]  STALL_LIMIT = 9'd256;

  state_t     state;
  logic [8:0] stall_cnt;
  logic [5:0] req_stall;
  logic       exc_taken;

  // Highest-priority stall request; a stall freezes its own stage and all earlier ones.
  always_comb begin
    req_stall = '0;
    if (stallreq_mem)      req_stall = 6'b011111;
    else if (stallreq_ex)  req_stall = 6'b001111;
    else if (stallreq_id)  req_stall = 6'b000111;
    else if (stallreq_if)  req_stall = 6'b000011;
  end

  // Exception flush overrides all stalls; outputs are held quiet while reset is asserted.
  always_comb begin
    exc_taken = (state == RUN) && (excepttype_i != '0);
    flush     = 1'b0;
    stall     = '0;
    new_pc    = '0;
    if (!rst) begin
      if (exc_taken) begin
        flush  = 1'b1;
        new_pc = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
      end else begin
        stall  = req_stall;
      end
    end
  end

  // FSM, exception counter and stall watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= RUN;
      stall_cnt       <= '0;
      stall_timeout_o <= 1'b0;
      exc_count_o     <= '0;
    end else begin
      case (state)
        RUN:     state <= flush ? BLANK : RUN;
        BLANK:   state <= RUN;
        default: state <= RUN;
      endcase

      if (flush && (exc_count_o != '1))
        exc_count_o <= exc_count_o + 16'd1;

      if (flush || (stall == '0)) begin
        stall_cnt <= '0;
      end else if (stall_cnt != STALL_LIMIT) begin
        stall_cnt <= stall_cnt + 9'd1;
      end

      if (!flush && (stall != '0) && (stall_cnt == STALL_LIMIT - 9'd1))
        stall_timeout_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vector table, hand-written corner sequences and a
// randomized run checked against a cycle-level reference model.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout_o;
  logic [15:0] exc_count_o;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit m_blank;
  int m_cnt;
  bit m_to;
  int m_exc;
  // model outputs for the current cycle
  logic [5:0]  e_stall;
  logic        e_flush;
  logic [31:0] e_pc;

  typedef struct {
    bit          fi, di, ex, me;
    logic [31:0] exc, epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[6];

  pipe_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .stallreq_if     (stallreq_if),
    .stallreq_id     (stallreq_id),
    .stallreq_ex     (stallreq_ex),
    .stallreq_mem    (stallreq_mem),
    .excepttype_i    (excepttype_i),
    .cp0_epc_i       (cp0_epc_i),
    .stall           (stall),
    .flush           (flush),
    .new_pc          (new_pc),
    .stall_timeout_o (stall_timeout_o),
    .exc_count_o     (exc_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit fi, input bit di, input bit ex, input bit me,
                       input logic [31:0] ec, input logic [31:0] ep);
    stallreq_if  = fi;
    stallreq_id  = di;
    stallreq_ex  = ex;
    stallreq_mem = me;
    excepttype_i = ec;
    cp0_epc_i    = ep;
  endtask

  task automatic model_reset();
    m_blank = 0;
    m_cnt   = 0;
    m_to    = 0;
    m_exc   = 0;
  endtask

  // Wait to mid-cycle and compute what the outputs must be right now.
  task automatic settle();
    int n;
    @(negedge clk);
    // number of frozen stages counted from the PC end
    n = stallreq_mem ? 5 : stallreq_ex ? 4 : stallreq_id ? 3 : stallreq_if ? 2 : 0;
    e_flush = !m_blank && (excepttype_i != 0);
    e_stall = e_flush ? 6'd0 : 6'((1 << n) - 1);
    e_pc    = !e_flush ? 32'd0 : (excepttype_i == 32'd14) ? cp0_epc_i : 32'd32;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".stall"},   {26'd0, stall}, {26'd0, e_stall});
    check({tag, ".flush"},   {31'd0, flush}, {31'd0, e_flush});
    check({tag, ".new_pc"},  new_pc, e_pc);
    check({tag, ".timeout"}, {31'd0, stall_timeout_o}, {31'd0, m_to});
    check({tag, ".exc_cnt"}, {16'd0, exc_count_o}, 32'(m_exc));
  endtask

  // Advance one clock edge and move the model along with it.
  task automatic commit();
    @(posedge clk);
    if (e_flush) begin
      m_blank = 1;
      if (m_exc < 65535) m_exc++;
    end else begin
      m_blank = 0;
    end
    if (e_flush || e_stall == 0) m_cnt = 0;
    else if (m_cnt < 256) m_cnt++;
    if (m_cnt == 256) m_to = 1;
    #1;
  endtask

  task automatic cycle(input string tag);
    settle();
    check_model(tag);
    commit();
  endtask

  initial begin
    tbl[0] = '{0,1,0,0, 32'h0, 32'h0,           6'b000111, 0, 32'h0,          16'd0};
    tbl[1] = '{0,1,0,1, 32'h0, 32'h0,           6'b011111, 0, 32'h0,          16'd0};
    tbl[2] = '{0,0,0,0, 32'h8, 32'h0,           6'b000000, 1, 32'h20,         16'd0};
    tbl[3] = '{0,0,0,0, 32'h8, 32'h0,           6'b000000, 0, 32'h0,          16'd1};
    tbl[4] = '{0,0,0,0, 32'he, 32'hBFC00104,    6'b000000, 1, 32'hBFC00104,   16'd1};
    tbl[5] = '{0,0,1,0, 32'h0, 32'h0,           6'b001111, 0, 32'h0,          16'd2};

    // reset with active requests: outputs must still be quiet
    rst = 1'b1;
    drive(0, 0, 1, 1, 32'h8, 32'h1234);
    model_reset();
    #12;
    check("reset.stall",   {26'd0, stall}, 32'd0);
    check("reset.flush",   {31'd0, flush}, 32'd0);
    check("reset.new_pc",  new_pc, 32'd0);
    check("reset.timeout", {31'd0, stall_timeout_o}, 32'd0);
    check("reset.exc_cnt", {16'd0, exc_count_o}, 32'd0);
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // directed table
    foreach (tbl[i]) begin
      drive(tbl[i].fi, tbl[i].di, tbl[i].ex, tbl[i].me, tbl[i].exc, tbl[i].epc);
      settle();
      check($sformatf("tbl%0d.stall", i),   {26'd0, stall}, {26'd0, tbl[i].stall});
      check($sformatf("tbl%0d.flush", i),   {31'd0, flush}, {31'd0, tbl[i].flush});
      check($sformatf("tbl%0d.new_pc", i),  new_pc, tbl[i].pc);
      check($sformatf("tbl%0d.exc_cnt", i), {16'd0, exc_count_o}, {16'd0, tbl[i].cnt});
      commit();
    end

    // exception together with an execute stall: flush wins, counter cleared
    drive(0, 0, 1, 0, 32'hc, 32'h0);
    settle();
    check("exc_ex.stall",  {26'd0, stall}, 32'd0);
    check("exc_ex.flush",  {31'd0, flush}, 32'd1);
    check("exc_ex.new_pc", new_pc, 32'h20);
    commit();
    check("exc_ex.stall_cnt", {23'd0, dut.stall_cnt}, 32'd0);

    // stall watchdog: mem stall held for 300 cycles
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    cycle("pre_wd");
    drive(0, 0, 0, 1, 32'h0, 32'h0);
    for (int k = 1; k <= 300; k++) begin
      cycle("wd");
      if (k == 255) check("wd.timeout_255", {31'd0, stall_timeout_o}, 32'd0);
      if (k == 256) check("wd.timeout_256", {31'd0, stall_timeout_o}, 32'd1);
    end
    check("wd.cnt_hold", {23'd0, dut.stall_cnt}, 32'd256);
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    cycle("wd_drop");
    cycle("wd_drop");
    check("wd.sticky", {31'd0, stall_timeout_o}, 32'd1);

    // five exceptions, ending in BLANK with a stall pending, then async reset
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 0, 32'h8, 32'h0);
      cycle("exc5");
      if (k < 4) begin
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        cycle("exc5_gap");
      end
    end
    drive(0, 0, 0, 1, 32'h8, 32'h0);
    settle();
    check("blank.exc_cnt", {16'd0, exc_count_o}, 32'd5);
    check("blank.flush",   {31'd0, flush}, 32'd0);
    check("blank.stall",   {26'd0, stall}, 32'h1f);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst.stall",   {26'd0, stall}, 32'd0);
    check("arst.flush",   {31'd0, flush}, 32'd0);
    check("arst.new_pc",  new_pc, 32'd0);
    check("arst.exc_cnt", {16'd0, exc_count_o}, 32'd0);
    check("arst.timeout", {31'd0, stall_timeout_o}, 32'd0);
    #3;
    rst = 1'b0;
    drive(0, 0, 0, 0, 32'h8, 32'h0);
    settle();
    check("post_rst.flush",  {31'd0, flush}, 32'd1);
    check("post_rst.new_pc", new_pc, 32'h20);
    commit();
    check("post_rst.exc_cnt", {16'd0, exc_count_o}, 32'd1);

    // randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      logic [31:0] ec;
      int sel;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       ec = 32'h8;
        1:       ec = 32'he;
        2:       ec = $urandom() | 32'h1;
        default: ec = 32'h0;
      endcase
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0),
            ec, $urandom());
      cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- stallreq_if  in  1  fetch stage requests a stall.
- stallreq_id  in  1  decode stage requests a stall.
- stallreq_ex  in  1  execute stage requests a stall (multi-cycle mult/div).
- stallreq_mem  in  1  memory stage requests a stall (bus wait).
- excepttype_i  in  32  exception code from the memory stage; 0 means none.
- cp0_epc_i  in  32  current EPC value from CP0.
- stall  out  6  pipeline freeze vector: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB.
- flush  out  1  clears every pipeline register and redirects the PC.
- new_pc  out  32  redirect target, valid only while flush=1.
- stall_timeout_o  out  1  sticky flag for a stall watchdog expiry.
- exc_count_o  out  16  saturating count of taken exceptions.
REQ-002 Reset SHALL be asynchronous and active-high on port rst, with single clock clk.

Function
REQ-003 stall, flush and new_pc SHALL be combinational from the inputs and the current FSM state, so they act in the same cycle as the request.
REQ-004 In state RUN with excepttype_i != 0, the block SHALL drive flush=1 and stall=6'b000000. This exception case has top priority over all stall requests.
REQ-005 new_pc SHALL equal cp0_epc_i when excepttype_i == 32'h0000000e (ERET).
REQ-006 For any other nonzero excepttype_i, new_pc SHALL equal 32'h00000020. While flush=0, new_pc SHALL be 0.
REQ-007 With no exception, stall SHALL follow the highest-priority active request:
- mem: 6'b011111
- ex: 6'b001111
- id: 6'b000111
- if: 6'b000011
- none: 6'b000000
REQ-008 The FSM SHALL have two states, RUN and BLANK.
- RUN to BLANK: on any cycle with flush=1.
- BLANK to RUN: unconditionally after exactly one cycle.
REQ-009 In BLANK, flush SHALL be 0, excepttype_i SHALL be ignored, and stall SHALL still follow REQ-007. This prevents a stale exception code from causing a second flush.
REQ-010 exc_count_o SHALL increment by 1 on each clock edge where flush=1 in RUN, and SHALL saturate at 16'hFFFF.
REQ-011 A 9-bit stall counter SHALL increment each cycle while stall != 0 and clear to 0 on any cycle with stall == 0 or flush=1.
REQ-012 When the stall counter reaches 256, stall_timeout_o SHALL be set to 1 on that edge and SHALL stay at 1 until reset. Once the counter reaches 256 it SHALL hold there while the stall persists.
REQ-013 The stall counter SHALL NOT wrap.
REQ-014 Simultaneous exception and any stall request SHALL give flush=1, stall=0, and the stall counter cleared.
REQ-015 Exceptions on back-to-back cycles SHALL flush only on the first cycle; the second cycle falls in BLANK and is dropped.

Reset
REQ-016 While rst=1, independent of clk, the outputs SHALL take these values:
- FSM = RUN
- stall counter = 0
- stall_timeout_o = 0
- exc_count_o = 0
- flush = 0
- stall = 0
- new_pc = 0
REQ-017 Asserting rst in BLANK or mid-stall SHALL abort immediately. The first cycle after release SHALL behave as RUN with counters at 0.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- stallreq_id=1 alone -> stall=000111, flush=0; add stallreq_mem=1 -> stall=011111 in the same cycle.
- excepttype_i=32'h00000008 in RUN -> flush=1, new_pc=32'h00000020, stall=0; next cycle flush=0 even if excepttype_i is unchanged; exc_count_o=1.
- excepttype_i=32'h0000000e, cp0_epc_i=32'hBFC00104 -> flush=1, new_pc=32'hBFC00104.
- stallreq_ex=1 and excepttype_i=32'h0000000c together -> flush=1, stall=0, stall counter 0.
- stallreq_mem held for 300 cycles -> stall_timeout_o rises on the 256th stalled edge and stays 1 after the request drops.
- rst pulsed asynchronously while in BLANK with exc_count_o=5 -> all outputs 0 immediately; a new exception after release gives flush=1 and exc_count_o=1.
